hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
//  Hazard controller sequencing the F/D, D/E, E/M and M/W pipeline registers of the 5-stage MIPS core.
//  - Detects RAW hazards between the D-stage source registers and the E/M-stage producers (Tuse/Tnew rule).
//  - Tracks the multi-cycle mult/div unit with a busy timer and stalls HI/LO-related instructions.
//  - Drives stall (hold PC + F/D) and flush (bubble into D/E); keeps a stall performance counter.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles after a mult/multu start
//  DIV_CYCLES   10  busy cycles after a div/divu start
//  CNT_W        4   busy-timer width; must hold DIV_CYCLES
//  PERF_W       16  stall performance counter width
// PORTS
//  clk          in   1       clock; all state updates on the rising edge
//  reset        in   1       reset, asynchronous, active-low (0 = reset)
//  D_rs         in   5       D-stage rs index
//  D_rt         in   5       D-stage rt index
//  D_tuse_rs    in   2       cycles until rs is needed (0..2); 3 = rs unused
//  D_tuse_rt    in   2       same for rt
//  D_md         in   1       D instruction uses the mult/div unit (mult/div/mfhi/mflo/mthi/mtlo)
//  E_A3         in   5       E-stage destination register (0 = none)
//  E_tnew       in   2       cycles until the E result is available (0..2)
//  M_A3         in   5       M-stage destination register (0 = none)
//  M_tnew       in   2       cycles until the M result is available (0..1)
//  E_start      in   2       mult/div start issued from E this cycle: 00 none, 01 mult, 10 div, 11 illegal
//  O_stall_D    out  1       hold PC and the F/D register
//  O_flush_E    out  1       clear the D/E register (bubble)
//  O_md_busy    out  1       mult/div unit busy (registered)
//  O_md_cnt     out  CNT_W   remaining busy cycles (registered)
//  O_err        out  1       sticky error: illegal or overlapping start
//  O_stall_cnt  out  PERF_W  saturating count of stalled cycles
// BEHAVIOUR
//  Reset (reset==0, asynchronous): O_md_cnt=0, O_md_busy=0, O_err=0, O_stall_cnt=0.
//   - Stall/flush are combinational and follow their inputs during reset.
//   - A busy timer interrupted by reset aborts to 0 immediately.
//  RAW stall (combinational, zero latency), per source s in {rs, rt}:
//   - stall_s = (D_s!=0) && ((E_A3==D_s && E_tnew>D_tuse_s) || (M_A3==D_s && M_tnew>D_tuse_s)).
//   - Register 0 never stalls. Tuse=3 never stalls because Tnew<=2.
//  MD stall: md_stall = D_md && (O_md_busy || E_start!=00).
//  O_stall_D = O_flush_E = stall_rs | stall_rt | md_stall. The two outputs are always equal.
//  Busy timer (registered), with priority in this order:
//   1. E_start==01 && !busy: cnt <= MULT_CYCLES.
//   2. E_start==10 && !busy: cnt <= DIV_CYCLES.
//   3. cnt!=0: cnt <= cnt-1.
//   - O_md_busy = (cnt!=0), registered alongside cnt.
//   - After a start edge, busy is high for exactly MULT_CYCLES (or DIV_CYCLES) cycles.
//   - A new start is accepted in the first cycle busy is low.
//  Errors: E_start==11, or E_start!=00 while busy.
//   - The start is ignored; the timer keeps counting; O_err <= 1 and stays set until reset.
//  Perf counter: +1 on each edge where O_stall_D==1; saturates at all-ones (no wrap).
//  Simultaneous events:
//   - A RAW stall and an MD stall in the same cycle produce a single stall; the perf counter increments once.
//   - A start arriving on the cycle cnt reaches 1->0 is ignored (busy is still high) and flags O_err.
// STRUCTURE
//  Shared package constants:
//   - MD_NONE=2'b00, MD_MULT=2'b01, MD_DIV=2'b10, MD_ILL=2'b11.
//   - TUSE_NONE=2'd3.
//   - Default MULT_CYCLES and DIV_CYCLES.
//  Sub-module md_busy_timer: holds the counter, busy and err registers, with start/cnt/busy/err ports.
//  Top level: combinational hazard compare, stall OR, perf counter.
// TESTING
//  1. Load-use: D_rs=8, D_tuse_rs=0, E_A3=8, E_tnew=2 -> stall=flush=1.
//     Next cycle: M_A3=8, M_tnew=1 -> stall=1; then M_tnew=0 -> stall=0. O_stall_cnt=2.
//  2. Zero register: D_rs=0, E_A3=0, E_tnew=2, D_tuse_rs=0 -> stall=0. D_tuse_rt=3 with a matching rt -> stall=0.
//  3. Mult: E_start=01 for one cycle -> busy high exactly 5 cycles, cnt 5,4,3,2,1,0.
//     D_md=1 throughout -> stall during the start cycle plus 5 busy cycles, then released.
//  4. Div then mult: E_start=10 -> 10 busy cycles.
//     E_start=01 at cnt=3 -> ignored, O_err=1, cnt continues 2,1,0.
//     E_start=11 on an idle unit -> ignored, O_err stays 1.
//  5. Reset mid-div: at cnt=6 drive reset=0 between clock edges -> cnt=0, busy=0, err=0, stall_cnt=0 immediately.
//  6. Saturation: force 2^PERF_W+3 stall cycles -> O_stall_cnt holds at all-ones.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline hazard / stall controller.
package hazard_stall_ctrl_pkg;

    localparam logic [1:0] MD_NONE = 2'b00;
    localparam logic [1:0] MD_MULT = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;
    localparam logic [1:0] MD_ILL  = 2'b11;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam int unsigned DEF_MULT_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES  = 10;

    // A producer blocks a consumer when its result arrives later than the consumer needs it.
    function automatic logic raw_hit(input logic [4:0] src, input logic [1:0] tuse,
                                     input logic [4:0] a3, input logic [1:0] tnew);
        return (src != 5'd0) && (tuse != TUSE_NONE) && (a3 == src) && (tnew > tuse);
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div occupancy timer: loads a cycle count on an accepted start and counts down to idle.
module md_busy_timer
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       start_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             busy_o,
    output logic             err_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i == MD_MULT && !busy_q) begin
            cnt_d = CNT_W'(MULT_CYCLES);
        end else if (start_i == MD_DIV && !busy_q) begin
            cnt_d = CNT_W'(DIV_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        busy_d = (cnt_d != '0);
        // Rejected starts (illegal code or issued while busy) latch the error until reset.
        err_d  = err_q | (start_i == MD_ILL) | ((start_i != MD_NONE) && busy_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign busy_o = busy_q;
    assign err_o  = err_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// RAW and mult/div hazard detection driving F/D stall and D/E flush, with a stall perf counter.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned PERF_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        D_rs,
    input  logic [4:0]        D_rt,
    input  logic [1:0]        D_tuse_rs,
    input  logic [1:0]        D_tuse_rt,
    input  logic              D_md,
    input  logic [4:0]        E_A3,
    input  logic [1:0]        E_tnew,
    input  logic [4:0]        M_A3,
    input  logic [1:0]        M_tnew,
    input  logic [1:0]        E_start,
    output logic              O_stall_D,
    output logic              O_flush_E,
    output logic              O_md_busy,
    output logic [CNT_W-1:0]  O_md_cnt,
    output logic              O_err,
    output logic [PERF_W-1:0] O_stall_cnt
);

    logic              stall_rs, stall_rt, md_stall, stall;
    logic              md_busy;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_timer (
        .clk     (clk),
        .reset   (reset),
        .start_i (E_start),
        .cnt_o   (O_md_cnt),
        .busy_o  (md_busy),
        .err_o   (O_err)
    );

    always_comb begin
        stall_rs = raw_hit(D_rs, D_tuse_rs, E_A3, E_tnew) | raw_hit(D_rs, D_tuse_rs, M_A3, M_tnew);
        stall_rt = raw_hit(D_rt, D_tuse_rt, E_A3, E_tnew) | raw_hit(D_rt, D_tuse_rt, M_A3, M_tnew);
        // A start issuing from E this cycle occupies the unit before busy is visible.
        md_stall = D_md && (md_busy || (E_start != MD_NONE));
        stall    = stall_rs | stall_rt | md_stall;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {PERF_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign O_stall_D   = stall;
    assign O_flush_E   = stall;
    assign O_md_busy   = md_busy;
    assign O_stall_cnt = stall_cnt_q;

endmodule
